// File: rtl/lockin_ref_pkg.sv
// Shared types and defaults for the lock-in reference generator.
// Also holds the elaboration-time sine table function.
package lockin_ref_pkg;
  localparam int PHASE_W_DEF    = 32;
  localparam int LUT_ADDR_W_DEF = 10;
  localparam int AMP_W_DEF      = 16;
  localparam int QUARTER        = (2**LUT_ADDR_W_DEF) / 4;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} ref_state_e;

  localparam real PI = 3.14159265358979323846;

  // Rounds half away from zero so the table is symmetric about zero
  function automatic int sine_word(input int idx, input int addr_w, input int amp_w);
    real peak, x;
    peak = real'((1 << (amp_w - 1)) - 1);
    x    = peak * $sin(2.0 * PI * real'(idx) / real'(1 << addr_w));
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction
endpackage

// File: rtl/ref_sine_lut.sv
// Dual-read synchronous full-wave sine ROM; both outputs registered (1 clk).
module ref_sine_lut import lockin_ref_pkg::*; #(
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int AMP_W      = AMP_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [LUT_ADDR_W-1:0]         addr_a,
  input  logic [LUT_ADDR_W-1:0]         addr_b,
  output logic signed [AMP_W-1:0]       data_a,
  output logic signed [AMP_W-1:0]       data_b
);
  localparam int LUT_SIZE = 2**LUT_ADDR_W;

  logic signed [AMP_W-1:0] rom [LUT_SIZE];

  for (genvar g = 0; g < LUT_SIZE; g++) begin : g_rom
    localparam logic signed [AMP_W-1:0] WORD = AMP_W'(sine_word(g, LUT_ADDR_W, AMP_W));
    assign rom[g] = WORD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end
endmodule

// File: rtl/reference_generator_li.sv
// Lock-in reference transmitter: FSM, phase accumulator, sync tracking, 2-stage sin/cos pipeline.
// Optional feature macro: REF_PHASE_OFFSET_EN (latched phase offset added before addressing).
module reference_generator_li import lockin_ref_pkg::*; #(
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int AMP_W      = AMP_W_DEF,
  parameter int PHASE_W    = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable_gral,
  input  logic               start,
  input  logic               stop,
  input  logic               wait_trigger,
  input  logic               trigger_in,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic               sample_tick,
  output logic [31:0]        ref_sen,
  output logic [31:0]        ref_cos,
  output logic               ref_valid,
  output logic               ref_sync,
  output logic               running,
  output logic [31:0]        cycles_done,
  output logic               cfg_error
);
  localparam int STAGES = 2;
  localparam logic [LUT_ADDR_W-1:0] QTR = LUT_ADDR_W'((2**LUT_ADDR_W) / 4);

  ref_state_e              state;
  logic [PHASE_W-1:0]      acc, inc_q, off;
  logic                    wt_q, carry_q;
  logic [PHASE_W:0]        acc_sum;
  logic [LUT_ADDR_W-1:0]   lut_addr, addr_sin, addr_cos;
  logic signed [AMP_W-1:0] lut_sin, lut_cos;
  logic                    tick_ok, sync_now;
  logic [STAGES:1]         vld_pipe, sync_pipe;

`ifdef REF_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] off_q;
  assign off = off_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      off_q <= '0;
    else if (state == IDLE && start && !stop && phase_inc != '0)
      off_q <= phase_offset;
  end
`else
  logic unused_offset;
  assign unused_offset = ^phase_offset;
  assign off = '0;
`endif

  assign acc_sum  = {1'b0, acc} + {1'b0, inc_q};
  assign lut_addr = LUT_ADDR_W'((acc + off) >> (PHASE_W - LUT_ADDR_W));
  assign tick_ok  = enable_gral && sample_tick && !stop &&
                    ((state == RUN) || (state == ARMED && (!wt_q || trigger_in)));
  // First sample of a run, or acc just wrapped (sync follows the unoffset phase)
  assign sync_now = (state == ARMED) || carry_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc         <= '0;
      inc_q       <= '0;
      wt_q        <= 1'b0;
      carry_q     <= 1'b0;
      running     <= 1'b0;
      cycles_done <= '0;
      cfg_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (phase_inc != '0) begin
              state       <= ARMED;
              inc_q       <= phase_inc;
              wt_q        <= wait_trigger;
              acc         <= '0;
              carry_q     <= 1'b0;
              cycles_done <= '0;
              cfg_error   <= 1'b0;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        ARMED, RUN: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (tick_ok) begin
            state   <= RUN;
            running <= 1'b1;
            acc     <= acc_sum[PHASE_W-1:0];
            carry_q <= acc_sum[PHASE_W];
            if (state == RUN && carry_q && cycles_done != '1)
              cycles_done <= cycles_done + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: LUT addresses; stage 2: ROM words. Stop flushes in-flight samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      sync_pipe <= '0;
      addr_sin  <= '0;
      addr_cos  <= '0;
    end else begin
      if (stop) begin
        vld_pipe  <= '0;
        sync_pipe <= '0;
      end else begin
        vld_pipe  <= {vld_pipe[STAGES-1:1], tick_ok};
        sync_pipe <= {sync_pipe[STAGES-1:1], tick_ok && sync_now};
      end
      if (tick_ok) begin
        addr_sin <= lut_addr;
        addr_cos <= lut_addr + QTR;
      end
    end
  end

  ref_sine_lut #(.LUT_ADDR_W(LUT_ADDR_W), .AMP_W(AMP_W)) u_lut (
    .clk    (clk),
    .reset_n(reset_n),
    .addr_a (addr_sin),
    .addr_b (addr_cos),
    .data_a (lut_sin),
    .data_b (lut_cos)
  );

  assign ref_sen   = 32'(lut_sin);
  assign ref_cos   = 32'(lut_cos);
  assign ref_valid = vld_pipe[STAGES];
  assign ref_sync  = sync_pipe[STAGES];
endmodule

// File: tb/tb_reference_generator_li.sv
// Directed, table-driven bench for reference_generator_li.
module tb_reference_generator_li;
  localparam logic [31:0] P = 32'd32767;
  localparam logic [31:0] N = 32'hFFFF_8001;
  localparam logic [31:0] Z = 32'd0;
  localparam logic [31:0] INC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset_n, enable_gral, start, stop, wait_trigger, trigger_in, sample_tick;
  logic [31:0] phase_inc, phase_offset;
  logic [31:0] ref_sen, ref_cos, cycles_done;
  logic        ref_valid, ref_sync, running, cfg_error;

  reference_generator_li dut (
    .clk(clk), .reset_n(reset_n), .enable_gral(enable_gral), .start(start), .stop(stop),
    .wait_trigger(wait_trigger), .trigger_in(trigger_in), .phase_inc(phase_inc),
    .phase_offset(phase_offset), .sample_tick(sample_tick), .ref_sen(ref_sen),
    .ref_cos(ref_cos), .ref_valid(ref_valid), .ref_sync(ref_sync), .running(running),
    .cycles_done(cycles_done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] sen, cos; logic sync; } obs_t;
  typedef struct { logic [31:0] sen, cos; logic sync; } vec_t;
  obs_t q[$];
  vec_t tbl[8];

  always @(negedge clk) if (ref_valid) q.push_back('{cyc, ref_sen, ref_cos, ref_sync});

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic one_tick();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
  endtask

  int t0;

  initial begin
    tbl[0] = '{Z, P, 1'b1}; tbl[1] = '{P, Z, 1'b0}; tbl[2] = '{Z, N, 1'b0}; tbl[3] = '{N, Z, 1'b0};
    tbl[4] = '{Z, P, 1'b1}; tbl[5] = '{P, Z, 1'b0}; tbl[6] = '{Z, N, 1'b0}; tbl[7] = '{N, Z, 1'b0};

    reset_n = 1'b0; enable_gral = 1'b1; start = 1'b0; stop = 1'b0; wait_trigger = 1'b0;
    trigger_in = 1'b0; sample_tick = 1'b0; phase_inc = '0; phase_offset = '0;
    step(2);
    chk("rst_valid", 32'(ref_valid), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_cycles", cycles_done, 0);
    chk("rst_cfg_error", 32'(cfg_error), 0);
    chk("rst_sen", ref_sen, 0);
    reset_n = 1'b1; step();

    // 1: quarter-wave step, tick coincident with the start edge must be ignored
    phase_inc = INC;
    start = 1'b1; sample_tick = 1'b1; step(); start = 1'b0; sample_tick = 1'b0;
    q.delete(); t0 = cyc;
    sample_tick = 1'b1; step(8); sample_tick = 1'b0; step(4);
    chk("t1_count", q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < q.size()) begin
        chk($sformatf("t1_lat[%0d]", i), q[i].cyc, t0 + i + 2);
        chk($sformatf("t1_sen[%0d]", i), q[i].sen, tbl[i].sen);
        chk($sformatf("t1_cos[%0d]", i), q[i].cos, tbl[i].cos);
        chk($sformatf("t1_sync[%0d]", i), 32'(q[i].sync), 32'(tbl[i].sync));
      end
    end
    chk("t1_running", 32'(running), 1);
    chk("t1_cycles", cycles_done, 1);
    do_stop();
    chk("t1_stopped", 32'(running), 0);

    // 2: trigger wait, then enable_gral gating
    wait_trigger = 1'b1; do_start(); q.delete();
    sample_tick = 1'b1; step(5);
    trigger_in = 1'b1; t0 = cyc; step(); trigger_in = 1'b0; sample_tick = 1'b0; step(3);
    chk("t2_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("t2_lat", q[0].cyc, t0 + 2);
      chk("t2_sen", q[0].sen, Z);
      chk("t2_cos", q[0].cos, P);
      chk("t2_sync", 32'(q[0].sync), 1);
    end
    enable_gral = 1'b0; sample_tick = 1'b1; step(3); sample_tick = 1'b0; enable_gral = 1'b1; step(3);
    chk("t2_en_low_count", q.size(), 1);
    chk("t2_en_low_running", 32'(running), 1);
    one_tick(); step(3);
    chk("t2_resume_count", q.size(), 2);
    if (q.size() > 1) begin
      chk("t2_resume_sen", q[1].sen, P);
      chk("t2_resume_sync", 32'(q[1].sync), 0);
    end
    do_stop(); wait_trigger = 1'b0;

    // 3: zero increment rejected, start+stop ignored, then a good start
    phase_inc = '0; do_start(); q.delete();
    chk("t3_cfg_set", 32'(cfg_error), 1);
    chk("t3_idle_running", 32'(running), 0);
    one_tick(); step(3);
    chk("t3_idle_tick", q.size(), 0);
    phase_inc = INC; start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t3_stop_wins_cfg", 32'(cfg_error), 1);
    one_tick(); step(3);
    chk("t3_stop_wins_tick", q.size(), 0);
    do_start();
    chk("t3_cfg_clear", 32'(cfg_error), 0);
    chk("t3_armed_running", 32'(running), 0);
    one_tick(); step(3);
    chk("t3_count", q.size(), 1);
    if (q.size() > 0) chk("t3_sync", 32'(q[0].sync), 1);
    do_stop();

    // 4: stop one clk after a RUN tick kills that sample
    do_start(); q.delete();
    one_tick(); step(3);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    do_stop();
    chk("t4_running", 32'(running), 0);
    step(4);
    chk("t4_count", q.size(), 1);
    one_tick(); step(3);
    chk("t4_idle_tick", q.size(), 1);

    // 5: asynchronous reset between edges mid-run
    do_start(); q.delete();
    sample_tick = 1'b1; step(5);
    chk("t5_pre_cycles", cycles_done, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_valid", 32'(ref_valid), 0);
    chk("t5_sync", 32'(ref_sync), 0);
    chk("t5_sen", ref_sen, 0);
    chk("t5_cos", ref_cos, 0);
    chk("t5_running", 32'(running), 0);
    chk("t5_cycles", cycles_done, 0);
    sample_tick = 1'b0; step(); reset_n = 1'b1; step();
    q.delete(); do_start();
    t0 = cyc; one_tick(); step(3);
    chk("t5_restart_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("t5_restart_lat", q[0].cyc, t0 + 2);
      chk("t5_restart_sen", q[0].sen, Z);
      chk("t5_restart_cos", q[0].cos, P);
      chk("t5_restart_sync", 32'(q[0].sync), 1);
    end
    do_stop();

`ifdef REF_PHASE_OFFSET_EN
    // 6: quarter-turn offset shifts the table, sync still on the first sample
    phase_offset = INC; do_start(); q.delete();
    one_tick(); step(3);
    chk("t6_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("t6_sen", q[0].sen, P);
      chk("t6_cos", q[0].cos, Z);
      chk("t6_sync", 32'(q[0].sync), 1);
    end
    do_stop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
